// File: rtl/sdvm_pkg.sv
// Shared definitions for the signed-digit by vector multiplier stream.
// Digit encodings and negation-mode selectors used by the RTL and the bench.
package sdvm_pkg;

  typedef enum logic [1:0] {
    DIG_ZERO = 2'b00,
    DIG_NEG  = 2'b01,
    DIG_POS  = 2'b10,
    DIG_INV  = 2'b11
  } digit_t;

  localparam int NEG_INVERT = 0;
  localparam int NEG_SWAP   = 1;

  function automatic logic is_invalid(input digit_t d);
    return d == DIG_INV;
  endfunction

endpackage

// File: rtl/sdvm_stream_if.sv
// Handshake bundle of the digit stream, the borrow-save vector input and the
// registered product output.
interface sdvm_stream_if #(
  parameter int WIDTH = 64
);

  logic [1:0]       digit_in;
  logic             digit_valid;
  logic             digit_ready;
  logic [WIDTH-1:0] vec_in_plus;
  logic [WIDTH-1:0] vec_in_minus;
  logic             vec_valid;
  logic             vec_ready;
  logic [WIDTH-1:0] vec_out_plus;
  logic [WIDTH-1:0] vec_out_minus;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output digit_in, digit_valid, vec_in_plus, vec_in_minus, vec_valid, out_ready,
    input  digit_ready, vec_ready, vec_out_plus, vec_out_minus, out_valid
  );

  modport slave (
    input  digit_in, digit_valid, vec_in_plus, vec_in_minus, vec_valid, out_ready,
    output digit_ready, vec_ready, vec_out_plus, vec_out_minus, out_valid
  );

endinterface

// File: rtl/sdvm_digit_fifo.sv
// Circular digit FIFO that comes out of reset/flush already holding DELAY zero
// digits, which is what turns it into the online delay line.
module sdvm_digit_fifo
  import sdvm_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DELAY = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             asyn_reset_n,
  input  logic             flush,
  input  logic             push,
  input  digit_t           push_digit,
  input  logic             pop,
  output digit_t           head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PRELOAD_PTR = PTR_W'(DELAY);
  localparam logic [CNT_W-1:0] PRELOAD_CNT = CNT_W'(DELAY);

  digit_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign head = mem[rd_ptr];

  // All entries are zero after reset/flush, so the preload is just the write pointer and count.
  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DIG_ZERO;
      rd_ptr <= '0;
      wr_ptr <= PRELOAD_PTR;
      count  <= PRELOAD_CNT;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DIG_ZERO;
      rd_ptr <= '0;
      wr_ptr <= PRELOAD_PTR;
      count  <= PRELOAD_CNT;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_digit;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdvm_stream.sv
// Online signed-digit times borrow-save vector multiplier: each accepted vector
// is scaled by the oldest queued digit and presented one cycle later.
module sdvm_stream
  import sdvm_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int DELAY    = 4,
  parameter int DEPTH    = 8,
  parameter int NEG_MODE = 0,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              asyn_reset_n,
  input  logic              enable,
  input  logic              flush,
  sdvm_stream_if.slave      bus,
  output logic [CNT_W-1:0]  digit_count,
  output logic              err
);

  logic             digit_ready;
  logic             vec_ready;
  logic             digit_fire;
  logic             vec_fire;
  logic             flush_now;
  digit_t           head;
  digit_t           new_digit;
  logic [WIDTH-1:0] prod_plus;
  logic [WIDTH-1:0] prod_minus;
  logic [WIDTH-1:0] out_plus_q;
  logic [WIDTH-1:0] out_minus_q;
  logic             out_valid_q;

  assign new_digit   = digit_t'(bus.digit_in);
  assign flush_now   = enable & flush;
  assign digit_ready = enable & ~flush & (digit_count < CNT_W'(DEPTH));
  assign vec_ready   = enable & ~flush & (digit_count != '0) & (~out_valid_q | bus.out_ready);
  assign digit_fire  = bus.digit_valid & digit_ready;
  assign vec_fire    = bus.vec_valid & vec_ready;

  sdvm_digit_fifo #(
    .DEPTH (DEPTH),
    .DELAY (DELAY)
  ) u_fifo (
    .clk          (clk),
    .asyn_reset_n (asyn_reset_n),
    .flush        (flush_now),
    .push         (digit_fire),
    .push_digit   (new_digit),
    .pop          (vec_fire),
    .head         (head),
    .count        (digit_count)
  );

  // Zero and invalid digits both annihilate the vector.
  always_comb begin
    prod_plus  = '0;
    prod_minus = '0;
    case (head)
      DIG_POS: begin
        prod_plus  = bus.vec_in_plus;
        prod_minus = bus.vec_in_minus;
      end
      DIG_NEG: begin
        if (NEG_MODE == NEG_SWAP) begin
          prod_plus  = bus.vec_in_minus;
          prod_minus = bus.vec_in_plus;
        end else begin
          prod_plus  = ~bus.vec_in_plus;
          prod_minus = ~bus.vec_in_minus;
        end
      end
      default: begin
        prod_plus  = '0;
        prod_minus = '0;
      end
    endcase
  end

  // Output register holds while the consumer stalls; enable low freezes everything, flush included.
  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      out_plus_q  <= '0;
      out_minus_q <= '0;
      out_valid_q <= 1'b0;
      err         <= 1'b0;
    end else if (enable) begin
      if (flush) begin
        out_plus_q  <= '0;
        out_minus_q <= '0;
        out_valid_q <= 1'b0;
        err         <= 1'b0;
      end else begin
        if (vec_fire) begin
          out_plus_q  <= prod_plus;
          out_minus_q <= prod_minus;
          out_valid_q <= 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
          out_valid_q <= 1'b0;
        end
        if (digit_fire && is_invalid(new_digit)) err <= 1'b1;
      end
    end
  end

  assign bus.digit_ready   = digit_ready;
  assign bus.vec_ready     = vec_ready;
  assign bus.vec_out_plus  = out_plus_q;
  assign bus.vec_out_minus = out_minus_q;
  assign bus.out_valid     = out_valid_q;

endmodule
